// File: rtl/pipe_pkg.sv
// Shared pipeline types: the stage occupancy enum and the packed inter-stage bundles.
// Instantiate pipe_stage_reg with DATA_W = $bits(<bundle>_t) for the stage it sits between.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stage_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } de_bundle_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_res;
    logic [4:0]  rd;
    logic        wb_en;
  } em_bundle_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its maximum value instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// Flow-controlled pipeline stage register with flush and back-pressure counter.
// Define PIPE_STAGE_SKID_EN for the 2-entry skid build with a registered in_ready.
//
// Handshake: a payload moves when valid && ready are both high at a rising edge;
// valid never waits on ready, and a held payload stays stable until it moves.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic              skid_full,
  output stage_state_e      dbg_state
);

  stage_state_e      r_state;
  stage_state_e      w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] w_main_nxt;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_stall;

  assign out_valid  = (r_state != ST_EMPTY);
  // An empty stage presents an all-zero NOP bubble downstream.
  assign out_data   = out_valid ? r_main : '0;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;
  assign w_stall    = out_valid && !out_ready;
  assign dbg_state  = r_state;

`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] r_skid;
  logic [DATA_W-1:0] w_skid_nxt;

  assign in_ready  = (r_state != ST_SKID) && !clear;
  assign skid_full = (r_state == ST_SKID);

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (clear) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = '0;
      w_skid_nxt  = '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = ST_FULL;
            w_main_nxt  = in_data;
          end
        end
        ST_FULL: begin
          if (w_in_fire && w_out_fire) begin
            w_main_nxt = in_data;
          end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;
          end else if (w_in_fire) begin
            w_state_nxt = ST_SKID;
            w_skid_nxt  = in_data;
          end
        end
        ST_SKID: begin
          if (w_out_fire) begin
            w_state_nxt = ST_FULL;
            w_main_nxt  = r_skid;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end
`else
  // Single entry: ready passes straight through from out_ready when full.
  assign in_ready  = (!out_valid || out_ready) && !clear;
  assign skid_full = 1'b0;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    if (clear) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = ST_FULL;
            w_main_nxt  = in_data;
          end
        end
        ST_FULL: begin
          if (w_in_fire) begin
            w_main_nxt = in_data;
          end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
    end
  end
`endif

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_stall),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: per-cycle vector table plus hand sequences for
// back-pressure, saturation, asynchronous reset and the build-specific ready path.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DW = $bits(de_bundle_t);
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] stall_cnt;
  logic          skid_full;
  stage_state_e  dbg_state;

  int n_total = 0;
  int n_bad   = 0;

  logic [DW-1:0] exp_q[$];

`ifdef PIPE_STAGE_SKID_EN
  localparam logic SKID_BUILD = 1'b1;
`else
  localparam logic SKID_BUILD = 1'b0;
`endif

  pipe_stage_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt),
    .skid_full (skid_full),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset();
    reset     = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic ordy, input logic clr);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    clear     = clr;
  endtask

  // ---------------- vector table ----------------
  // Expected values are the outputs seen during the cycle, before its rising edge.
  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          ordy;
    logic          clr;
    logic          e_ov;
    logic [DW-1:0] e_od;
    logic          e_ir;
    logic [CW-1:0] e_stall;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b1, 64'h1, 1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 4'd0};
    vecs[1] = '{1'b1, 64'h2, 1'b1, 1'b0, 1'b1, 64'h1, 1'b1, 4'd0};
    vecs[2] = '{1'b1, 64'h3, 1'b1, 1'b0, 1'b1, 64'h2, 1'b1, 4'd0};
    vecs[3] = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 64'h3, 1'b1, 4'd0};
    vecs[4] = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 4'd0};
    // fill then flush while a new payload is offered
    vecs[5] = '{1'b1, 64'h5, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 4'd0};
    vecs[6] = '{1'b1, 64'h6, 1'b0, 1'b1, 1'b1, 64'h5, 1'b0, 4'd0};
    vecs[7] = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 4'd1};
    // clear on an empty stage refuses the offered payload
    vecs[8] = '{1'b1, 64'h7, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 4'd1};
    vecs[9] = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 4'd1};

    do_reset();
    #1;
    check("reset_out_valid", DW'(out_valid), DW'(1'b0));
    check("reset_out_data",  out_data,       '0);
    check("reset_in_ready",  DW'(in_ready),  DW'(1'b1));
    check("reset_skid_full", DW'(skid_full), DW'(1'b0));
    check("reset_stall_cnt", DW'(stall_cnt), '0);

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].ordy, vecs[i].clr);
      #1;
      check($sformatf("vec%0d_out_valid", i), DW'(out_valid), DW'(vecs[i].e_ov));
      check($sformatf("vec%0d_out_data", i),  out_data,       vecs[i].e_od);
      check($sformatf("vec%0d_in_ready", i),  DW'(in_ready),  DW'(vecs[i].e_ir));
      check($sformatf("vec%0d_stall", i),     DW'(stall_cnt), DW'(vecs[i].e_stall));
    end

    // ---------------- back-pressure: 0xA, 0xB, 0xC with out_ready held low ----------------
    begin
      logic [DW-1:0] src[3];
      int idx;
      int cyc;
      src[0] = 64'hA;
      src[1] = 64'hB;
      src[2] = 64'hC;
      do_reset();
      exp_q = {64'hA, 64'hB, 64'hC};
      idx = 0;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 40) begin
        drive(idx < 3, (idx < 3) ? src[idx] : '0, cyc >= 5, 1'b0);
        #1;
        if (cyc == 2) begin
          check("bp_in_ready_blocked", DW'(in_ready),  DW'(1'b0));
          check("bp_skid_full",        DW'(skid_full), DW'(SKID_BUILD));
        end
        if (out_valid && out_ready) begin
          check($sformatf("bp_order%0d", 3 - exp_q.size()), out_data, exp_q.pop_front());
        end
        if (in_valid && in_ready) idx++;
        cyc++;
      end
      check("bp_drained_in_time", DW'(exp_q.size()), '0);
      drive(1'b0, '0, 1'b1, 1'b0);
      #1;
      check("bp_stall_cnt", DW'(stall_cnt), DW'(4));
      check("bp_empty_after", DW'(out_valid), DW'(1'b0));
    end

`ifdef PIPE_STAGE_SKID_EN
    // ---------------- flush from SKID holding 0xA, 0xB ----------------
    do_reset();
    drive(1'b1, 64'hA, 1'b0, 1'b0);
    drive(1'b1, 64'hB, 1'b0, 1'b0);
    drive(1'b1, 64'hD, 1'b0, 1'b1);
    #1;
    check("flush_skid_before", DW'(skid_full), DW'(1'b1));
    check("flush_in_ready_low", DW'(in_ready), DW'(1'b0));
    drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    check("flush_out_valid", DW'(out_valid), DW'(1'b0));
    check("flush_out_data",  out_data,       '0);
    check("flush_in_ready",  DW'(in_ready),  DW'(1'b1));
    check("flush_skid_after", DW'(skid_full), DW'(1'b0));
    // in_ready must not follow out_ready within a cycle
    drive(1'b1, 64'hE, 1'b0, 1'b0);
    drive(1'b1, 64'hF, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    check("skid_ready_low", DW'(in_ready), DW'(1'b0));
    out_ready = 1'b1;
    #1;
    check("skid_ready_registered", DW'(in_ready), DW'(1'b0));
    drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    check("skid_second_out", out_data, 64'hF);
    check("skid_ready_back", DW'(in_ready), DW'(1'b1));
`else
    // ---------------- single entry: combinational ready from out_ready ----------------
    do_reset();
    drive(1'b1, 64'h11, 1'b1, 1'b0);
    drive(1'b1, 64'h22, 1'b0, 1'b0);
    #1;
    check("comb_ready_low", DW'(in_ready), DW'(1'b0));
    out_ready = 1'b1;
    #1;
    check("comb_ready_high", DW'(in_ready), DW'(1'b1));
    check("comb_first_out",  out_data,      64'h11);
    drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    check("comb_no_bubble_valid", DW'(out_valid), DW'(1'b1));
    check("comb_no_bubble_data",  out_data,       64'h22);
`endif

    // ---------------- stall counter saturation ----------------
    do_reset();
    drive(1'b1, 64'h33, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, '0, 1'b0, 1'b0);
      #1;
      if (i == 14) check("sat_count14", DW'(stall_cnt), DW'(14));
    end
    check("sat_count_max", DW'(stall_cnt), DW'(15));
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    check("sat_clear_keeps", DW'(stall_cnt), DW'(15));
    check("sat_clear_empties", DW'(out_valid), DW'(1'b0));

    // ---------------- asynchronous reset between edges ----------------
    do_reset();
    drive(1'b1, 64'h44, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    check("arst_pre_valid", DW'(out_valid), DW'(1'b1));
    check("arst_pre_stall", DW'(stall_cnt), DW'(1));
    #1;
    reset = 1'b1;
    #1;
    check("arst_out_valid", DW'(out_valid), DW'(1'b0));
    check("arst_out_data",  out_data,       '0);
    check("arst_stall",     DW'(stall_cnt), '0);
    check("arst_in_ready",  DW'(in_ready),  DW'(1'b1));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst_stays_empty", DW'(out_valid), DW'(1'b0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, bad=%0d", n_bad);
    $fatal(1);
  end

endmodule
